// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target with a small byte-addressed register memory.
// Supports write (pointer + data bytes), pointer-set, and current-address /
// sequential reads. SDA is only ever pulled low; SCL is never stretched.
module i2c_target_mem #(
    parameter logic [6:0]  TargetAddr = 7'h50,
    parameter int unsigned MemDepth   = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_en_o,
    output logic       busy_o,
    output logic       wr_strobe_o,
    output logic [7:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    localparam int unsigned AW = $clog2(MemDepth);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_e;

    logic          scl_meta_q, scl_sync_q, scl_prev_q;
    logic          sda_meta_q, sda_sync_q, sda_prev_q;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    tx_q;
    logic          rw_q;
    logic          ack_hold_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    mem_q [MemDepth];
    logic          sda_en_q;
    logic          busy_q;
    logic          wr_strobe_q;
    logic [7:0]    wr_addr_q;
    logic [7:0]    wr_data_q;

    logic          scl_rise, scl_fall;
    logic          start_cond, stop_cond;
    logic [7:0]    shift_d;
    logic [3:0]    cnt_d;
    logic [AW-1:0] ptr_d;
    logic [7:0]    rd_byte;

    // Bus event decode from the synchronised lines; START/STOP need SCL high in both samples
    always_comb begin
        scl_rise   = scl_sync_q & ~scl_prev_q;
        scl_fall   = ~scl_sync_q & scl_prev_q;
        start_cond = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
        stop_cond  = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;
        shift_d    = {shift_q[6:0], sda_sync_q};
        cnt_d      = cnt_q + 4'd1;
        ptr_d      = ptr_q + AW'(1);
        rd_byte    = mem_q[ptr_q];
    end

    // Two-flop synchronisers plus a delayed copy for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl_i;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda_i;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    // Protocol FSM, memory, pointer and all registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= 8'h00;
            tx_q        <= 8'h00;
            rw_q        <= 1'b0;
            ack_hold_q  <= 1'b0;
            ptr_q       <= '0;
            sda_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 8'h00;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < int'(MemDepth); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_cond) begin
                // Repeated start is legal anywhere; a partial byte is dropped
                state_q    <= ST_ADDR;
                cnt_q      <= 4'd0;
                ack_hold_q <= 1'b0;
                sda_en_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else if (stop_cond) begin
                state_q    <= ST_IDLE;
                cnt_q      <= 4'd0;
                ack_hold_q <= 1'b0;
                sda_en_q   <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            if (cnt_q == 4'd7) begin
                                cnt_q <= 4'd0;
                                if (shift_d[7:1] == TargetAddr) begin
                                    state_q    <= ST_ADDR_ACK;
                                    rw_q       <= shift_d[0];
                                    ack_hold_q <= 1'b0;
                                    busy_q     <= 1'b1;
                                end else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                        // First fall asserts ACK, second fall ends the ACK slot
                        if (scl_fall) begin
                            if (!ack_hold_q) begin
                                sda_en_q   <= 1'b1;
                                ack_hold_q <= 1'b1;
                            end else begin
                                ack_hold_q <= 1'b0;
                                cnt_q      <= 4'd0;
                                if (state_q == ST_ADDR_ACK && rw_q) begin
                                    state_q  <= ST_RDATA;
                                    sda_en_q <= ~rd_byte[7];
                                    tx_q     <= {rd_byte[6:0], 1'b0};
                                    cnt_q    <= 4'd1;
                                end else begin
                                    sda_en_q <= 1'b0;
                                    state_q  <= (state_q == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            if (cnt_q == 4'd7) begin
                                cnt_q   <= 4'd0;
                                ptr_q   <= shift_d[AW-1:0];
                                state_q <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift_q <= shift_d;
                            cnt_q   <= cnt_d;
                            if (cnt_q == 4'd7) begin
                                cnt_q        <= 4'd0;
                                mem_q[ptr_q] <= shift_d;
                                wr_strobe_q  <= 1'b1;
                                wr_addr_q    <= 8'(ptr_q);
                                wr_data_q    <= shift_d;
                                ptr_q        <= ptr_d;
                                state_q      <= ST_WDATA_ACK;
                            end
                        end
                    end
                    ST_RDATA: begin
                        // cnt_q counts bits already placed on the bus; 0 means load a new byte
                        if (scl_fall) begin
                            if (cnt_q == 4'd0) begin
                                sda_en_q <= ~rd_byte[7];
                                tx_q     <= {rd_byte[6:0], 1'b0};
                                cnt_q    <= 4'd1;
                            end else if (cnt_q == 4'd8) begin
                                sda_en_q <= 1'b0;
                                ptr_q    <= ptr_d;
                                cnt_q    <= 4'd0;
                                state_q  <= ST_RDATA_ACK;
                            end else begin
                                sda_en_q <= ~tx_q[7];
                                tx_q     <= {tx_q[6:0], 1'b0};
                                cnt_q    <= cnt_d;
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            if (!sda_sync_q) begin
                                state_q <= ST_RDATA;
                                cnt_q   <= 4'd0;
                            end else begin
                                state_q <= ST_IGNORE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        sda_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_en_o    = sda_en_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: drives an open-drain I2C bus as the initiator and
// scores write strobes and read bytes against a memory/pointer model.
module tb_i2c_target_mem;

    localparam int HalfT = 8;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       scl_drv;
    logic       sda_ctl;
    logic       sda_bus;
    logic       sda_en_o;
    logic       busy_o;
    logic       wr_strobe_o;
    logic [7:0] wr_addr_o;
    logic [7:0] wr_data_o;

    int         checks = 0;
    int         errors = 0;

    logic [7:0] mem_model [16];
    logic [3:0] ptr_model;
    wr_t        wr_exp_q [$];
    logic [7:0] rd_exp_q [$];
    logic       saw_sda_en;
    logic       saw_busy;

    always #5 clk = ~clk;

    assign sda_bus = sda_ctl & ~sda_en_o;

    i2c_target_mem #(
        .TargetAddr(7'h50),
        .MemDepth  (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .scl_i      (scl_drv),
        .sda_i      (sda_bus),
        .sda_en_o   (sda_en_o),
        .busy_o     (busy_o),
        .wr_strobe_o(wr_strobe_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o)
    );

    initial begin
        #800000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Every bus delay goes through here; strobes are scored as they appear.
    task automatic wait_t();
        wr_t e;
        repeat (HalfT) begin
            @(negedge clk);
            if (sda_en_o === 1'b1) saw_sda_en = 1'b1;
            if (busy_o === 1'b1) saw_busy = 1'b1;
            if (wr_strobe_o === 1'b1) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected got addr=%h data=%h exp none", wr_addr_o, wr_data_o);
                end else begin
                    e = wr_exp_q.pop_front();
                    if ({wr_addr_o, wr_data_o} !== {e.addr, e.data}) begin
                        errors++;
                        $display("FAIL strobe got addr=%h data=%h exp addr=%h data=%h",
                                 wr_addr_o, wr_data_o, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic bus_start();
        sda_ctl = 1'b1; wait_t();
        scl_drv = 1'b1; wait_t();
        sda_ctl = 1'b0; wait_t();
        scl_drv = 1'b0; wait_t();
    endtask

    task automatic bus_stop();
        sda_ctl = 1'b0; wait_t();
        scl_drv = 1'b1; wait_t();
        sda_ctl = 1'b1; wait_t();
    endtask

    task automatic put_bit(input logic b);
        sda_ctl = b;    wait_t();
        scl_drv = 1'b1; wait_t();
        scl_drv = 1'b0; wait_t();
    endtask

    task automatic get_bit(output logic b);
        sda_ctl = 1'b1; wait_t();
        scl_drv = 1'b1; wait_t();
        b = sda_bus;
        scl_drv = 1'b0; wait_t();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~ack);
    endtask

    // Model side: expected strobe / read byte queued before the bus traffic
    task automatic model_write(input logic [7:0] v);
        wr_exp_q.push_back({4'h0, ptr_model, v});
        mem_model[ptr_model] = v;
        ptr_model = ptr_model + 4'd1;
    endtask

    task automatic model_read();
        rd_exp_q.push_back(mem_model[ptr_model]);
        ptr_model = ptr_model + 4'd1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_model[i] = 8'h00;
        ptr_model = 4'd0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; scl_drv = 1'b1; sda_ctl = 1'b1;
        saw_sda_en = 1'b0; saw_busy = 1'b0;
        model_reset();
        wait_t();
        checks++; if (sda_en_o !== 1'b0) begin errors++; $display("FAIL rst_sda_en got=%b exp=0", sda_en_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
        checks++; if (wr_strobe_o !== 1'b0) begin errors++; $display("FAIL rst_strobe got=%b exp=0", wr_strobe_o); end
        checks++; if (wr_addr_o !== 8'h00) begin errors++; $display("FAIL rst_wr_addr got=%h exp=00", wr_addr_o); end
        checks++; if (wr_data_o !== 8'h00) begin errors++; $display("FAIL rst_wr_data got=%h exp=00", wr_data_o); end
        rst_ni = 1'b1;
        wait_t();
    endtask

    // T1: pointer 03 then two data bytes
    task automatic test_write();
        logic ack;
        logic [7:0] bytes [3];
        bytes[0] = 8'h03; bytes[1] = 8'h5A; bytes[2] = 8'hC3;
        bus_start();
        put_byte(8'hA0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t1_addr_ack got=%b exp=1", ack); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_addressed got=%b exp=1", busy_o); end
        ptr_model = bytes[0][3:0];
        for (int i = 0; i < 3; i++) begin
            if (i > 0) model_write(bytes[i]);
            put_byte(bytes[i], ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t1_byte%0d_ack got=%b exp=1", i, ack); end
        end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy_before_stop got=%b exp=1", busy_o); end
        bus_stop();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy_after_stop got=%b exp=0", busy_o); end
        checks++; if (wr_exp_q.size() != 0) begin errors++; $display("FAIL t1_missing_strobes got=%0d pending exp=0", wr_exp_q.size()); end
    endtask

    // T2: set pointer, repeated start, sequential read; then a current-address read
    task automatic test_random_read();
        logic ack;
        logic [7:0] d, e;
        bus_start();
        put_byte(8'hA0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t2_addr_ack got=%b exp=1", ack); end
        put_byte(8'h03, ack); ptr_model = 4'h3;
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t2_ptr_ack got=%b exp=1", ack); end
        bus_start();
        put_byte(8'hA1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t2_raddr_ack got=%b exp=1", ack); end
        for (int i = 0; i < 2; i++) begin
            model_read();
            get_byte(d, (i == 0));
            e = rd_exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL t2_read%0d got=%h exp=%h", i, d, e); end
        end
        bus_stop();
        bus_start();
        put_byte(8'hA1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t2_cur_addr_ack got=%b exp=1", ack); end
        model_read();
        get_byte(d, 1'b0);
        e = rd_exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL t2_cur_read got=%h exp=%h", d, e); end
        bus_stop();
    endtask

    // T3: pointer wraps from 0F to 00 on write and on read
    task automatic test_wrap();
        logic ack;
        logic [7:0] d, e;
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack); ptr_model = 4'hF;
        model_write(8'h11); put_byte(8'h11, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t3_w0_ack got=%b exp=1", ack); end
        model_write(8'h22); put_byte(8'h22, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t3_w1_ack got=%b exp=1", ack); end
        bus_stop();
        checks++; if (wr_exp_q.size() != 0) begin errors++; $display("FAIL t3_missing_strobes got=%0d pending exp=0", wr_exp_q.size()); end
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h0F, ack); ptr_model = 4'hF;
        bus_start();
        put_byte(8'hA1, ack);
        for (int i = 0; i < 2; i++) begin
            model_read();
            get_byte(d, (i == 0));
            e = rd_exp_q.pop_front();
            checks++; if (d !== e) begin errors++; $display("FAIL t3_read%0d got=%h exp=%h", i, d, e); end
        end
        bus_stop();
    endtask

    // T4: other address and general call are ignored entirely
    task automatic test_mismatch();
        logic ack;
        saw_sda_en = 1'b0; saw_busy = 1'b0;
        bus_start();
        put_byte(8'hA2, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t4_addr_nack got=%b exp=0", ack); end
        put_byte(8'h55, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t4_data_nack got=%b exp=0", ack); end
        bus_stop();
        bus_start();
        put_byte(8'h00, ack);
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL t4_gencall_nack got=%b exp=0", ack); end
        bus_stop();
        checks++; if (saw_sda_en !== 1'b0) begin errors++; $display("FAIL t4_sda_en_seen got=%b exp=0", saw_sda_en); end
        checks++; if (saw_busy !== 1'b0) begin errors++; $display("FAIL t4_busy_seen got=%b exp=0", saw_busy); end
    endtask

    // T5: data byte cut short by STOP, then a complete write
    task automatic test_abort();
        logic ack;
        logic [7:0] d, e;
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h02, ack); ptr_model = 4'h2;
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop();
        checks++; if (sda_en_o !== 1'b0) begin errors++; $display("FAIL t5_sda_released got=%b exp=0", sda_en_o); end
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h02, ack); ptr_model = 4'h2;
        bus_start();
        put_byte(8'hA1, ack);
        model_read();
        get_byte(d, 1'b0);
        e = rd_exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL t5_mem2_unchanged got=%h exp=%h", d, e); end
        bus_stop();
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h02, ack); ptr_model = 4'h2;
        model_write(8'h77); put_byte(8'h77, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t5_write_ack got=%b exp=1", ack); end
        bus_stop();
        checks++; if (wr_exp_q.size() != 0) begin errors++; $display("FAIL t5_missing_strobes got=%0d pending exp=0", wr_exp_q.size()); end
    endtask

    // T6: reset while the target pulls SDA low during a read
    task automatic test_reset_mid_read();
        logic ack;
        logic [7:0] d, e;
        bus_start();
        put_byte(8'hA0, ack);
        put_byte(8'h02, ack); ptr_model = 4'h2;
        bus_start();
        put_byte(8'hA1, ack);
        checks++; if (sda_en_o !== 1'b1) begin errors++; $display("FAIL t6_driving_bit7 got=%b exp=1", sda_en_o); end
        @(negedge clk);
        rst_ni = 1'b0;
        @(posedge clk); #1;
        checks++; if (sda_en_o !== 1'b0) begin errors++; $display("FAIL t6_sda_after_reset got=%b exp=0", sda_en_o); end
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        model_reset();
        wait_t();
        bus_start();
        put_byte(8'hA1, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL t6_raddr_ack got=%b exp=1", ack); end
        model_read();
        get_byte(d, 1'b0);
        e = rd_exp_q.pop_front();
        checks++; if (d !== e) begin errors++; $display("FAIL t6_read_ptr0 got=%h exp=%h", d, e); end
        bus_stop();
    endtask

    initial begin
        test_reset();
        test_write();
        test_random_read();
        test_wrap();
        test_mismatch();
        test_abort();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
